// File: rtl/hc00_in_debounce.sv
// Two-channel synchroniser plus debouncer that feeds clean levels to the hc00 NAND inputs.
// Optional edge pulses a_chg/b_chg are built only when HC00_DBNC_EDGE_EN is defined.
module hc00_in_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 16,
   parameter int CNT_W       = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a_raw,
   input  logic b_raw,
   output logic a_db,
   output logic b_db,
   output logic stable
`ifdef HC00_DBNC_EDGE_EN
   ,
   output logic a_chg,
   output logic b_chg
`endif
);

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_CHECK  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic [1:0] raw_vec;
   logic [1:0] db_vec;
   logic [1:0] stable_next_vec;
   logic       stable_reg;
`ifdef HC00_DBNC_EDGE_EN
   logic [1:0] chg_vec;
`endif

   assign raw_vec = {b_raw, a_raw};

   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   s;
      state_t                 state_reg, state_next;
      logic [CNT_W-1:0]       cnt_reg, cnt_next;
      logic                   db_reg, db_next;

      // Plain flop chain: nothing may sit between stages.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            sync_reg <= '0;
         end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_vec[gi]};
         end
      end

      assign s = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_reg <= ST_STABLE;
            cnt_reg   <= '0;
            db_reg    <= 1'b0;
         end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            db_reg    <= db_next;
         end
      end

      always_comb begin
         state_next = state_reg;
         cnt_next   = cnt_reg;
         db_next    = db_reg;
         case (state_reg)
            ST_STABLE: begin
               if (s != db_reg) begin
                  state_next = ST_CHECK;
                  cnt_next   = CNT_W'(1);
               end else begin
                  cnt_next   = '0;
               end
            end
            ST_CHECK: begin
               if (s == db_reg) begin
                  state_next = ST_STABLE;
                  cnt_next   = '0;
               end else if (cnt_reg == CNT_MAX) begin
                  // Enough consecutive differing samples: accept the new level.
                  db_next    = s;
                  cnt_next   = '0;
                  state_next = ST_STABLE;
               end else begin
                  cnt_next   = cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               state_next = ST_STABLE;
               cnt_next   = '0;
            end
         endcase
      end

      assign db_vec[gi]          = db_reg;
      assign stable_next_vec[gi] = (state_next == ST_STABLE);

`ifdef HC00_DBNC_EDGE_EN
      logic chg_reg;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            chg_reg <= 1'b0;
         end else begin
            chg_reg <= (db_next != db_reg);
         end
      end

      assign chg_vec[gi] = chg_reg;
`endif
   end

   // Registered from next-state so it lines up with the state registers it describes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stable_reg <= 1'b1;
      end else begin
         stable_reg <= &stable_next_vec;
      end
   end

   assign a_db   = db_vec[0];
   assign b_db   = db_vec[1];
   assign stable = stable_reg;
`ifdef HC00_DBNC_EDGE_EN
   assign a_chg  = chg_vec[0];
   assign b_chg  = chg_vec[1];
`endif

endmodule
